// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with per-register busy scoreboard,
//            registered reads and write-collision flag. Optional write-first
//            bypass when REGFILE_BYPASS_EN is defined (read-first otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int XLEN      = 64,
  parameter int ADDR_SIZE = 5,
  parameter int NUM_REGS  = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*ADDR_SIZE-1:0] wr_addr,
  input  logic [NUM_WR*XLEN-1:0]      wr_data,
  input  logic [NUM_RD-1:0]           rd_en,
  input  logic [NUM_RD*ADDR_SIZE-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]      rd_data,
  output logic [NUM_RD-1:0]           rd_busy,
  input  logic                        issue_en,
  input  logic [ADDR_SIZE-1:0]        issue_addr,
  output logic                        wr_conflict
);

  logic [XLEN-1:0]        r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]    r_busy;
  logic [NUM_RD*XLEN-1:0] r_rd_data;
  logic [NUM_RD-1:0]      r_rd_busy;
  logic                   r_conflict;

  logic [NUM_REGS-1:0]    w_wr_hit;
  logic [XLEN-1:0]        w_wr_val [NUM_REGS];
  logic [NUM_REGS-1:0]    w_busy_nxt;
  logic [NUM_RD*XLEN-1:0] w_rd_data;
  logic [NUM_RD-1:0]      w_rd_busy;
  logic                   w_conflict;

  // Ascending port scan: the highest-indexed enabled port lands last and wins.
  always_comb begin
    w_wr_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_wr_val[r] = '0;
    end
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i] && (wr_addr[i*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(r))) begin
          w_wr_hit[r] = 1'b1;
          w_wr_val[r] = wr_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int k = i + 1; k < NUM_WR; k++) begin
        if (wr_en[i] && wr_en[k] &&
            (wr_addr[i*ADDR_SIZE +: ADDR_SIZE] == wr_addr[k*ADDR_SIZE +: ADDR_SIZE]) &&
            (wr_addr[i*ADDR_SIZE +: ADDR_SIZE] != '0)) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  // Issue takes precedence over a same-cycle writeback; x0 is never busy.
  always_comb begin
    w_busy_nxt = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_busy_nxt[r] = (issue_en && (issue_addr == ADDR_SIZE'(r))) ||
                      (r_busy[r] && !w_wr_hit[r]);
    end
  end

  always_comb begin
    w_rd_data = r_rd_data;
    w_rd_busy = r_rd_busy;
    for (int j = 0; j < NUM_RD; j++) begin
      if (rd_en[j]) begin
        w_rd_data[j*XLEN +: XLEN] = '0;
        w_rd_busy[j]              = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
          if (rd_addr[j*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(r)) begin
`ifdef REGFILE_BYPASS_EN
            w_rd_data[j*XLEN +: XLEN] = w_wr_hit[r] ? w_wr_val[r] : r_regs[r];
`else
            w_rd_data[j*XLEN +: XLEN] = r_regs[r];
`endif
            w_rd_busy[j] = w_busy_nxt[r];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
      r_busy     <= '0;
      r_rd_data  <= '0;
      r_rd_busy  <= '0;
      r_conflict <= 1'b0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_wr_hit[r]) begin
          r_regs[r] <= w_wr_val[r];
        end
      end
      r_busy     <= w_busy_nxt;
      r_rd_data  <= w_rd_data;
      r_rd_busy  <= w_rd_busy;
      r_conflict <= w_conflict;
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_busy     = r_rd_busy;
  assign wr_conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Self-checking bench for regfile_mp against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
  localparam int XLEN = 64;
  localparam int AS   = 5;
  localparam int NR   = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AS-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AS-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                issue_en;
  logic [AS-1:0]       issue_addr;
  logic                wr_conflict;

  regfile_mp #(
    .XLEN(XLEN), .ADDR_SIZE(AS), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_en(issue_en), .issue_addr(issue_addr), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] m_regs [NR];
  bit              m_busy [NR];
  logic [XLEN-1:0] m_rd_data [NRD];
  bit              m_rd_busy [NRD];
  bit              m_conflict;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: apply writes in port order, then issue, then serve reads.
  task automatic model_edge();
    logic [XLEN-1:0] nxt [NR];
    bit              nb [NR];
    int              hits [2**AS];
    int              a;
    if (rst) begin
      for (int r = 0; r < NR; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
      for (int j = 0; j < NRD; j++) begin m_rd_data[j] = '0; m_rd_busy[j] = 0; end
      m_conflict = 0;
      return;
    end
    nxt = m_regs;
    nb  = m_busy;
    for (int k = 0; k < 2**AS; k++) hits[k] = 0;
    for (int i = 0; i < NWR; i++) begin
      a = int'(wr_addr[i*AS +: AS]);
      if (wr_en[i] && a != 0) begin
        hits[a]++;
        if (a < NR) begin nxt[a] = wr_data[i*XLEN +: XLEN]; nb[a] = 0; end
      end
    end
    m_conflict = 0;
    for (int k = 0; k < 2**AS; k++) if (hits[k] > 1) m_conflict = 1;
    a = int'(issue_addr);
    if (issue_en && a != 0 && a < NR) nb[a] = 1;
    for (int j = 0; j < NRD; j++) begin
      a = int'(rd_addr[j*AS +: AS]);
      if (rd_en[j]) begin
        if (a == 0 || a >= NR) begin
          m_rd_data[j] = '0;
          m_rd_busy[j] = 0;
        end else begin
`ifdef REGFILE_BYPASS_EN
          m_rd_data[j] = nxt[a];
`else
          m_rd_data[j] = m_regs[a];
`endif
          m_rd_busy[j] = nb[a];
        end
      end
    end
    m_regs = nxt;
    m_busy = nb;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int j = 0; j < NRD; j++) begin
      check($sformatf("rd_data%0d", j), rd_data[j*XLEN +: XLEN], m_rd_data[j]);
      check($sformatf("rd_busy%0d", j), XLEN'(rd_busy[j]), XLEN'(m_rd_busy[j]));
    end
    check("wr_conflict", XLEN'(wr_conflict), XLEN'(m_conflict));
  endtask

  task automatic cyc(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                     input logic [63:0] wd0, input logic [63:0] wd1,
                     input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                     input logic ie, input logic [4:0] ia);
    wr_en      = we;
    wr_addr    = {wa1, wa0};
    wr_data    = {wd1, wd0};
    rd_en      = re;
    rd_addr    = {ra1, ra0};
    issue_en   = ie;
    issue_addr = ia;
    tick();
  endtask

  task automatic idle();
    cyc(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; issue_en = 1'b0; issue_addr = '0;
    for (int r = 0; r < NR; r++) begin m_regs[r] = 'x; m_busy[r] = 0; end
    for (int j = 0; j < NRD; j++) begin m_rd_data[j] = '0; m_rd_busy[j] = 0; end
    m_conflict = 0;
    tick();
    tick();
    rst = 1'b0;

    for (int r = 1; r < NR; r++) cyc(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 2'b11, 5'(r), 5'(r), 1'b0, 5'd0);

    cyc(2'b01, 5'd5, 5'd0, 64'hDEAD_BEEF, 64'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
    cyc(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 2'b10, 5'd0, 5'd5, 1'b0, 5'd0);
    check("x5_direct", rd_data[XLEN +: XLEN], 64'hDEAD_BEEF);

    cyc(2'b11, 5'd7, 5'd7, 64'd1, 64'd2, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
    check("conflict_direct", XLEN'(wr_conflict), 64'd1);
    cyc(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0);
    check("x7_direct", rd_data[0 +: XLEN], 64'd2);
    check("conflict_clear", XLEN'(wr_conflict), 64'd0);

    cyc(2'b01, 5'd0, 5'd0, 64'hFFFF, 64'd0, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0);
    cyc(2'b11, 5'd0, 5'd0, 64'hFFFF, 64'h1234, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0);
    check("x0_zero", rd_data[0 +: XLEN], 64'd0);

    cyc(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9);
    cyc(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0);
    check("x9_busy", XLEN'(rd_busy[0]), 64'd1);
    cyc(2'b10, 5'd0, 5'd9, 64'd0, 64'h42, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0);
    check("x9_wb_busy", XLEN'(rd_busy[0]), 64'd0);
`ifdef REGFILE_BYPASS_EN
    check("x9_wb_data", rd_data[0 +: XLEN], 64'h42);
`else
    check("x9_wb_data", rd_data[0 +: XLEN], 64'd0);
`endif
    cyc(2'b01, 5'd9, 5'd0, 64'h43, 64'd0, 2'b10, 5'd0, 5'd9, 1'b1, 5'd9);
    check("x9_issue_wins", XLEN'(rd_busy[1]), 64'd1);

    cyc(2'b01, 5'd3, 5'd0, 64'h10, 64'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd4);
    rst = 1'b1;
    cyc(2'b01, 5'd3, 5'd0, 64'h11, 64'd0, 2'b11, 5'd3, 5'd4, 1'b1, 5'd4);
    rst = 1'b0;
    check("rst_rd_data", rd_data[0 +: XLEN], 64'd0);
    cyc(2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 2'b11, 5'd3, 5'd4, 1'b0, 5'd0);
    check("rst_x3", rd_data[0 +: XLEN], 64'd0);
    check("rst_x4_busy", XLEN'(rd_busy[1]), 64'd0);
    idle();

    for (int n = 0; n < 600; n++) begin
      logic [4:0] lim;
      lim = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31;
      rst = ($urandom_range(0, 49) == 0);
      cyc(2'($urandom), 5'($urandom_range(0, int'(lim))), 5'($urandom_range(0, int'(lim))),
          {$urandom, $urandom}, {$urandom, $urandom},
          2'($urandom), 5'($urandom_range(0, int'(lim))), 5'($urandom_range(0, int'(lim))),
          1'($urandom), 5'($urandom_range(0, int'(lim))));
    end
    rst = 1'b0;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
